// File: rtl/adder_pkg.sv
// Shared definitions for the wide sequential adder: chunk width, FSM states
// and index sizing.
package adder_pkg;

    localparam int CHUNK_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A chunk index needs at least one bit, even when there is only one chunk.
    function automatic int idx_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/wide_add_seq_if.sv
// Operand and result handshakes of the wide sequential adder.
interface wide_add_seq_if #(
    parameter int WORDS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WORDS*32-1:0]   A;
    logic [WORDS*32-1:0]   B;
    logic                  Cin;
    logic                  out_valid;
    logic                  out_ready;
    logic [WORDS*32-1:0]   S;
    logic                  Cout;

    modport master (
        output in_valid, A, B, Cin, out_ready,
        input  in_ready, out_valid, S, Cout
    );

    modport slave (
        input  in_valid, A, B, Cin, out_ready,
        output in_ready, out_valid, S, Cout
    );
endinterface

// File: rtl/CSLA32Bit.sv
// 32-bit carry-select adder: the upper half is precomputed for both carry
// values and chosen by the carry out of the lower half.
module CSLA32Bit (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cin,
    output logic [31:0] S,
    output logic        Cout
);
    logic [16:0] lo;
    logic [16:0] hi0;
    logic [16:0] hi1;

    assign lo  = {1'b0, A[15:0]}  + {1'b0, B[15:0]}  + {16'b0, Cin};
    assign hi0 = {1'b0, A[31:16]} + {1'b0, B[31:16]};
    assign hi1 = {1'b0, A[31:16]} + {1'b0, B[31:16]} + 17'd1;

    assign S    = {(lo[16] ? hi1[15:0] : hi0[15:0]), lo[15:0]};
    assign Cout = lo[16] ? hi1[16] : hi0[16];
endmodule

// File: rtl/wide_add_seq.sv
// Adds two WORDS x 32-bit operands by streaming them LSW first through one
// 32-bit carry-select adder, chaining the carry between chunks.
module wide_add_seq
    import adder_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic          clk,
    input  logic          rst,
    wide_add_seq_if.slave bus
);
    localparam int W  = WORDS * CHUNK_W;
    localparam int IW = idx_w(WORDS);
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   idx;
    logic [W-1:0]    a_buf;
    logic [W-1:0]    b_buf;
    logic [W-1:0]    s_reg;
    logic            carry;
    logic            cout_reg;
    logic            in_rdy;
    logic            out_vld;
    logic            accept;
    logic [CHUNK_W-1:0] add_s;
    logic            add_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_rdy    = 1'b0;
        out_vld   = 1'b0;
        case (state)
            IDLE: begin
                in_rdy = 1'b1;
                if (bus.in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (idx == LAST) state_nxt = DONE;
            end
            DONE: begin
                out_vld = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // in_ready must read low for as long as reset is held, not just after it.
    assign bus.in_ready  = in_rdy & ~rst;
    assign bus.out_valid = out_vld;
    assign bus.S         = s_reg;
    assign bus.Cout      = cout_reg;
    assign accept        = in_rdy & bus.in_valid;

    // The low chunk of each operand buffer always feeds the adder.
    CSLA32Bit u_csla (
        .A    (a_buf[CHUNK_W-1:0]),
        .B    (b_buf[CHUNK_W-1:0]),
        .Cin  (carry),
        .S    (add_s),
        .Cout (add_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_buf    <= '0;
            b_buf    <= '0;
            s_reg    <= '0;
            carry    <= 1'b0;
            cout_reg <= 1'b0;
            idx      <= '0;
        end else if (accept) begin
            a_buf <= bus.A;
            b_buf <= bus.B;
            carry <= bus.Cin;
            idx   <= '0;
        end else if (state == RUN) begin
            a_buf <= a_buf >> CHUNK_W;
            b_buf <= b_buf >> CHUNK_W;
            s_reg[idx*CHUNK_W +: CHUNK_W] <= add_s;
            carry <= add_c;
            if (idx == LAST) begin
                cout_reg <= add_c;
                idx      <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_wide_add_seq.sv
// Directed and randomized checks of wide_add_seq with WORDS=4.
module tb_wide_add_seq;
    localparam int WORDS = 4;
    localparam int W     = WORDS * 32;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   cyc;

    wide_add_seq_if #(.WORDS(WORDS)) bus ();

    wide_add_seq #(.WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operation and hold in_valid until the edge that accepts it.
    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          output int cyc_at, output bit ok);
        bus.A = a;
        bus.B = b;
        bus.Cin = c;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            if (bus.in_ready) ok = 1'b1;
            tick();
        end
        cyc_at = cyc;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            if (bus.out_valid) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.S !== '0) begin bad++; $display("FAIL reset_S got=%h want=0", bus.S); end
        total++; if (bus.Cout !== 1'b0) begin bad++; $display("FAIL reset_Cout got=%b want=0", bus.Cout); end
        rst = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b want=1", bus.in_ready); end
        tick();
    endtask

    task automatic test_all_ones();
        int c0; bit ok;
        accept({W{1'b1}}, '0, 1'b1, c0, ok);
        total++; if (!ok) begin bad++; $display("FAIL ones_accept got=timeout want=accept"); end
        tick(); tick(); tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL ones_early_valid got=%b want=0", bus.out_valid); end
        tick();
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL ones_latency got=%b want=1", bus.out_valid); end
        total++; if (bus.S !== '0) begin bad++; $display("FAIL ones_S got=%h want=0", bus.S); end
        total++; if (bus.Cout !== 1'b1) begin bad++; $display("FAIL ones_Cout got=%b want=1", bus.Cout); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL ones_release got=v%b r%b want=v0 r1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_chunk_carry();
        int c0; bit ok;
        accept(128'h00000000_00000000_00000000_FFFFFFFF, 128'h1, 1'b0, c0, ok);
        wait_valid(ok);
        total++; if (!ok) begin bad++; $display("FAIL carry_wait got=timeout want=out_valid"); end
        total++; if (bus.S !== 128'h00000000_00000000_00000001_00000000) begin
            bad++; $display("FAIL carry_S got=%h want=%h", bus.S, 128'h00000000_00000000_00000001_00000000);
        end
        total++; if (bus.Cout !== 1'b0) begin bad++; $display("FAIL carry_Cout got=%b want=0", bus.Cout); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int c0; bit ok;
        logic [W-1:0] exp_s;
        exp_s = 128'hEF2DEDB6_FFFFFFFF_9999999A_00000001;
        accept(128'hFFABCEDC_FFFF0000_12345678_80000000,
               128'hEF821EDA_0000FFFF_87654321_80000000, 1'b1, c0, ok);
        wait_valid(ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_wait got=timeout want=out_valid"); end
        for (int i = 0; i < 5; i++) begin
            total++; if (bus.out_valid !== 1'b1 || bus.S !== exp_s || bus.Cout !== 1'b1 || bus.in_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold%0d got=v%b r%b c%b S=%h want=v1 r0 c1 S=%h",
                                i, bus.out_valid, bus.in_ready, bus.Cout, bus.S, exp_s);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b want=1", bus.in_ready); end
    endtask

    task automatic test_mid_reset();
        int c0; bit ok;
        accept(128'h11111111_22222222_33333333_44444444,
               128'h11111111_22222222_33333333_44444444, 1'b0, c0, ok);
        tick();
        tick();
        rst = 1'b1;
        #1;
        total++; if (bus.out_valid !== 1'b0 || bus.S !== '0 || bus.Cout !== 1'b0 || bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL midrst_outputs got=v%b r%b c%b S=%h want=v0 r0 c0 S=0",
                            bus.out_valid, bus.in_ready, bus.Cout, bus.S);
        end
        tick();
        rst = 1'b0;
        #1;
        accept(128'd2017701177, 128'd1701853, 1'b0, c0, ok);
        wait_valid(ok);
        total++; if (!ok) begin bad++; $display("FAIL midrst_wait got=timeout want=out_valid"); end
        total++; if (bus.S !== 128'd2019403030 || bus.Cout !== 1'b0) begin
            bad++; $display("FAIL midrst_sum got=c%b S=%0d want=c0 S=2019403030", bus.Cout, bus.S);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_hold_valid();
        int c0; int seen; bit ok;
        accept(128'd5, 128'd7, 1'b0, c0, ok);
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            if (bus.out_valid) ok = 1'b1;
            else begin
                bus.A = {$urandom, $urandom, $urandom, $urandom};
                bus.B = {$urandom, $urandom, $urandom, $urandom};
                tick();
            end
        end
        total++; if (!ok) begin bad++; $display("FAIL hold_wait got=timeout want=out_valid"); end
        total++; if (bus.S !== 128'd12 || bus.Cout !== 1'b0) begin
            bad++; $display("FAIL hold_sum got=c%b S=%h want=c0 S=c", bus.Cout, bus.S);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        seen = 0;
        for (int t = 0; t < 8; t++) begin
            if (bus.out_valid) seen++;
            tick();
        end
        total++; if (seen !== 0 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL hold_extra_result got=%0d r%b want=0 r1", seen, bus.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b;
        logic         c;
        logic [W:0]   exp;
        int  acc_cyc, prev;
        bit  ok, done;
        prev = 0;
        for (int n = 0; n < 1000; n++) begin
            a = {$urandom, $urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom, $urandom};
            if (n % 10 == 0) a = {W{1'b1}};
            c = 1'($urandom_range(0, 1));
            exp = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
            accept(a, b, c, acc_cyc, ok);
            total++; if (!ok) begin bad++; $display("FAIL b2b_accept%0d got=timeout want=accept", n); end
            if (n > 0) begin
                total++; if (acc_cyc - prev < WORDS + 2) begin
                    bad++; $display("FAIL b2b_spacing%0d got=%0d want>=%0d", n, acc_cyc - prev, WORDS + 2);
                end
            end
            prev = acc_cyc;
            done = 1'b0;
            for (int t = 0; t < 100 && !done; t++) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                if (bus.out_valid && bus.out_ready) begin
                    total++; if ({bus.Cout, bus.S} !== exp) begin
                        bad++; $display("FAIL b2b_sum%0d got=%h want=%h", n, {bus.Cout, bus.S}, exp);
                    end
                    done = 1'b1;
                end
                tick();
            end
            bus.out_ready = 1'b0;
            total++; if (!done) begin bad++; $display("FAIL b2b_result%0d got=timeout want=handshake", n); end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.Cin = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_all_ones();
        test_chunk_carry();
        test_backpressure();
        test_mid_reset();
        test_hold_valid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
